// File: rtl/dma_pkg.sv
// Shared types and constants for the PIM DMA engine: FSM state encoding
// and the command direction codes carried on funct3.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_PIM_PUSH = 3'd3,
        ST_PIM_PULL = 3'd4,
        ST_WR_REQ   = 3'd5
    } dma_state_e;

    localparam logic [2:0] DMA_M2P = 3'b000;
    localparam logic [2:0] DMA_P2M = 3'b001;

    localparam logic [3:0]  MEM_STRB_WORD = 4'b1111;
    localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/dma_engine.sv
// Word-at-a-time DMA between data memory and a PIM unit. One buffered word
// is moved per iteration in either direction; all outputs are registered.
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SIZE_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              dma_en_i,
    input  logic [2:0]        dma_funct3_i,
    input  logic [3:0]        dma_sel_pim_i,
    input  logic [SIZE_W-1:0] dma_size_i,
    input  logic [XLEN-1:0]   dma_mem_addr_i,
    output logic              dma_busy_o,
    output logic              dma_done_o,

    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wr_data_o,
    input  logic [XLEN-1:0]   mem_rd_data_i,
    output logic [3:0]        mem_size_o,
    output logic              mem_read_o,
    output logic              mem_write_o,

    output logic [3:0]        pim_sel_o,
    output logic              pim_wr_valid_o,
    input  logic              pim_wr_ready_i,
    output logic [XLEN-1:0]   pim_wr_data_o,
    input  logic              pim_rd_valid_i,
    output logic              pim_rd_ready_o,
    input  logic [XLEN-1:0]   pim_rd_data_i
);

    dma_state_e        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [SIZE_W-1:0] count_q, count_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [3:0]        sel_q, sel_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              req_q, req_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [3:0]        strb_q, strb_d;
    logic              wr_valid_q, wr_valid_d;
    logic              rd_ready_q, rd_ready_d;

    logic              cmd_ok_c;
    logic              last_word_c;
    logic [XLEN-1:0]   addr_next_c;
    logic [SIZE_W-1:0] count_next_c;

    assign cmd_ok_c     = ((dma_funct3_i == DMA_M2P) || (dma_funct3_i == DMA_P2M))
                          && (dma_size_i != '0);
    assign last_word_c  = (count_q <= SIZE_W'(1));
    assign addr_next_c  = addr_q + XLEN'(WORD_BYTES);
    assign count_next_c = (count_q != '0) ? count_q - SIZE_W'(1) : '0;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        buf_d   = buf_q;
        sel_d   = sel_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dma_en_i) begin
                    if (cmd_ok_c) begin
                        sel_d   = dma_sel_pim_i;
                        count_d = dma_size_i;
                        addr_d  = dma_mem_addr_i & ~XLEN'(WORD_BYTES - 1);
                        state_d = (dma_funct3_i == DMA_M2P) ? ST_RD_REQ : ST_PIM_PULL;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (mem_gnt_i) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                buf_d   = mem_rd_data_i;
                state_d = ST_PIM_PUSH;
            end
            ST_PIM_PUSH: begin
                if (pim_wr_ready_i) begin
                    addr_d  = addr_next_c;
                    count_d = count_next_c;
                    done_d  = last_word_c;
                    state_d = last_word_c ? ST_IDLE : ST_RD_REQ;
                end
            end
            ST_PIM_PULL: begin
                if (pim_rd_valid_i) begin
                    buf_d   = pim_rd_data_i;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (mem_gnt_i) begin
                    addr_d  = addr_next_c;
                    count_d = count_next_c;
                    done_d  = last_word_c;
                    state_d = last_word_c ? ST_IDLE : ST_PIM_PULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they line up with it once registered
        busy_d     = (state_d != ST_IDLE);
        req_d      = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        read_d     = (state_d == ST_RD_REQ);
        write_d    = (state_d == ST_WR_REQ);
        strb_d     = req_d ? MEM_STRB_WORD : 4'b0000;
        wr_valid_d = (state_d == ST_PIM_PUSH);
        rd_ready_d = (state_d == ST_PIM_PULL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            sel_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            strb_q     <= '0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            req_q      <= req_d;
            read_q     <= read_d;
            write_q    <= write_d;
            strb_q     <= strb_d;
            wr_valid_q <= wr_valid_d;
            rd_ready_q <= rd_ready_d;
        end
    end

    assign dma_busy_o     = busy_q;
    assign dma_done_o     = done_q;
    assign mem_req_o      = req_q;
    assign mem_read_o     = read_q;
    assign mem_write_o    = write_q;
    assign mem_size_o     = strb_q;
    assign mem_addr_o     = addr_q;
    assign mem_wr_data_o  = buf_q;
    assign pim_sel_o      = sel_q;
    assign pim_wr_valid_o = wr_valid_q;
    assign pim_wr_data_o  = buf_q;
    assign pim_rd_ready_o = rd_ready_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: table of commands with hand-computed
// busy length and word counts, plus a mid-transfer reset sequence.
module tb_dma_engine;
    import dma_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SIZE_W = 13;

    logic              clk_i;
    logic              rst_ni;
    logic              dma_en_i;
    logic [2:0]        dma_funct3_i;
    logic [3:0]        dma_sel_pim_i;
    logic [SIZE_W-1:0] dma_size_i;
    logic [XLEN-1:0]   dma_mem_addr_i;
    logic              dma_busy_o, dma_done_o;
    logic              mem_req_o, mem_gnt_i;
    logic [XLEN-1:0]   mem_addr_o, mem_wr_data_o, mem_rd_data_i;
    logic [3:0]        mem_size_o;
    logic              mem_read_o, mem_write_o;
    logic [3:0]        pim_sel_o;
    logic              pim_wr_valid_o, pim_wr_ready_i;
    logic [XLEN-1:0]   pim_wr_data_o;
    logic              pim_rd_valid_i, pim_rd_ready_o;
    logic [XLEN-1:0]   pim_rd_data_i;

    dma_engine #(.XLEN(XLEN), .SIZE_W(SIZE_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i), .dma_sel_pim_i(dma_sel_pim_i),
        .dma_size_i(dma_size_i), .dma_mem_addr_i(dma_mem_addr_i),
        .dma_busy_o(dma_busy_o), .dma_done_o(dma_done_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i), .mem_size_o(mem_size_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .pim_sel_o(pim_sel_o), .pim_wr_valid_o(pim_wr_valid_o), .pim_wr_ready_i(pim_wr_ready_i),
        .pim_wr_data_o(pim_wr_data_o), .pim_rd_valid_i(pim_rd_valid_i),
        .pim_rd_ready_o(pim_rd_ready_o), .pim_rd_data_i(pim_rd_data_i)
    );

    typedef struct {
        logic [2:0]        f3;
        logic [3:0]        sel;
        logic [SIZE_W-1:0] size;
        logic [XLEN-1:0]   addr;
        int                gdly;
        int                rdly;
        bit                poke;
        int                exp_busy;
        int                exp_words;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int n_cmp, n_err;
    int gnt_dly, rdy_dly, req_age, vld_age, pim_idx;
    int busy_cnt, done_cnt, act_cnt, stable_err;
    logic [XLEN-1:0] rd_q[$], pw_q[$], wa_q[$], wd_q[$];
    logic [3:0]      ws_q[$];
    logic [3:0]      seen_sel;
    logic [XLEN-1:0] pim_src [4];
    bit              prev_req_wait, prev_vld_wait;
    logic [XLEN-1:0] prev_addr, prev_vdata;

    function automatic logic [XLEN-1:0] mem_f(input logic [XLEN-1:0] a);
        return (a ^ 32'hA5A5_5A5A) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always #5 clk_i = ~clk_i;

    // Memory grant and PIM handshake models, driven 1 time unit after the edge
    always begin
        @(posedge clk_i); #1;
        if (mem_req_o) begin mem_gnt_i = (req_age >= gnt_dly); req_age++; end
        else begin mem_gnt_i = 1'b0; req_age = 0; end
        if (pim_wr_valid_o) begin pim_wr_ready_i = (vld_age >= rdy_dly); vld_age++; end
        else begin pim_wr_ready_i = 1'b0; vld_age = 0; end
        pim_rd_valid_i = pim_rd_ready_o && (pim_idx < 4);
        pim_rd_data_i  = (pim_rd_valid_i && pim_idx < 4) ? pim_src[pim_idx] : '0;
    end

    // Observe handshakes at the falling edge; read data returned for the next cycle
    always @(negedge clk_i) begin
        if (rst_ni) begin
            busy_cnt += int'(dma_busy_o);
            done_cnt += int'(dma_done_o);
            act_cnt  += int'(mem_req_o | pim_wr_valid_o | pim_rd_ready_o);
            if (prev_req_wait && (!mem_req_o || mem_addr_o !== prev_addr)) stable_err++;
            if (prev_vld_wait && (!pim_wr_valid_o || pim_wr_data_o !== prev_vdata)) stable_err++;
            prev_req_wait = mem_req_o && !mem_gnt_i;
            prev_addr     = mem_addr_o;
            prev_vld_wait = pim_wr_valid_o && !pim_wr_ready_i;
            prev_vdata    = pim_wr_data_o;
            if (mem_req_o && mem_gnt_i && mem_read_o) begin
                rd_q.push_back(mem_addr_o);
                mem_rd_data_i = mem_f(mem_addr_o);
                seen_sel = pim_sel_o;
            end
            if (mem_req_o && mem_gnt_i && mem_write_o) begin
                wa_q.push_back(mem_addr_o);
                wd_q.push_back(mem_wr_data_o);
                ws_q.push_back(mem_size_o);
                seen_sel = pim_sel_o;
            end
            if (pim_wr_valid_o && pim_wr_ready_i) pw_q.push_back(pim_wr_data_o);
            if (pim_rd_ready_o && pim_rd_valid_i) pim_idx++;
        end else begin
            prev_req_wait = 1'b0;
            prev_vld_wait = 1'b0;
        end
    end

    task automatic clear_obs();
        busy_cnt = 0; done_cnt = 0; act_cnt = 0; stable_err = 0; pim_idx = 0;
        rd_q.delete(); pw_q.delete(); wa_q.delete(); wd_q.delete(); ws_q.delete();
        seen_sel = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [XLEN-1:0] ea;
        bit              m2p;
        int              t;
        @(posedge clk_i); #1;
        clear_obs();
        gnt_dly = v.gdly; rdy_dly = v.rdly;
        dma_en_i = 1'b1; dma_funct3_i = v.f3; dma_sel_pim_i = v.sel;
        dma_size_i = v.size; dma_mem_addr_i = v.addr;
        @(posedge clk_i); #1;
        dma_en_i = 1'b0;
        // Values a stray second command would carry if it were wrongly accepted
        dma_funct3_i = DMA_P2M; dma_sel_pim_i = 4'hF; dma_size_i = 13'd5; dma_mem_addr_i = 32'h5000_0000;
        t = 0;
        while (done_cnt == 0 && t < 400) begin
            dma_en_i = v.poke && (t == 2);
            @(posedge clk_i); #1;
            t++;
        end
        dma_en_i = 1'b0;
        repeat (4) begin @(posedge clk_i); #1; end
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_busy"}, busy_cnt, v.exp_busy);
        chk({tag, "_stable"}, stable_err, 0);
        m2p = (v.f3 == DMA_M2P);
        if (v.exp_words == 0) begin
            chk({tag, "_activity"}, act_cnt, 0);
        end else begin
            chk({tag, "_nwords"}, m2p ? pw_q.size() : wa_q.size(), v.exp_words);
            chk({tag, "_other_dir"}, m2p ? wa_q.size() : pw_q.size(), 0);
            chk({tag, "_sel"}, seen_sel, v.sel);
            for (int i = 0; i < v.exp_words; i++) begin
                ea = (v.addr & ~32'h3) + 32'(4 * i);
                if (m2p) begin
                    if (i < rd_q.size()) chk($sformatf("%s_rdaddr%0d", tag, i), rd_q[i], ea);
                    if (i < pw_q.size()) chk($sformatf("%s_pimword%0d", tag, i), pw_q[i], mem_f(ea));
                end else begin
                    if (i < wa_q.size()) begin
                        chk($sformatf("%s_wraddr%0d", tag, i), wa_q[i], ea);
                        chk($sformatf("%s_wrdata%0d", tag, i), wd_q[i], pim_src[i]);
                        chk($sformatf("%s_strb%0d", tag, i), ws_q[i], 4'hF);
                    end
                end
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {dma_busy_o, dma_done_o, mem_req_o, mem_read_o, mem_write_o,
                             pim_wr_valid_o, pim_rd_ready_o, mem_size_o, pim_sel_o}, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wr_data_o, 0);
        chk({tag, "_pdata"}, pim_wr_data_o, 0);
    endtask

    initial begin
        int t;
        clk_i = 1'b0; rst_ni = 1'b0;
        dma_en_i = 1'b0; dma_funct3_i = '0; dma_sel_pim_i = '0; dma_size_i = '0; dma_mem_addr_i = '0;
        mem_gnt_i = 1'b0; mem_rd_data_i = '0; pim_wr_ready_i = 1'b0;
        pim_rd_valid_i = 1'b0; pim_rd_data_i = '0;
        n_cmp = 0; n_err = 0; gnt_dly = 0; rdy_dly = 0; req_age = 0; vld_age = 0;
        prev_req_wait = 1'b0; prev_vld_wait = 1'b0; prev_addr = '0; prev_vdata = '0;
        clear_obs();
        pim_src[0] = 32'hDEAD_BEEF; pim_src[1] = 32'h1234_5678;
        pim_src[2] = 32'hCAFE_F00D; pim_src[3] = 32'h0BAD_F00D;

        //          f3       sel   size    addr          gdly rdly poke busy words
        vecs[0] = '{DMA_M2P, 4'h3, 13'd4, 32'h1000_0100, 0, 0, 1'b0, 12, 4};
        vecs[1] = '{DMA_P2M, 4'h5, 13'd2, 32'h1000_0200, 0, 0, 1'b0,  4, 2};
        vecs[2] = '{DMA_M2P, 4'h9, 13'd2, 32'h2000_0040, 5, 3, 1'b0, 22, 2};
        vecs[3] = '{DMA_M2P, 4'h1, 13'd0, 32'h1000_0000, 0, 0, 1'b0,  0, 0};
        vecs[4] = '{3'b010,  4'h2, 13'd3, 32'h0000_1234, 0, 0, 1'b0,  0, 0};
        vecs[5] = '{DMA_M2P, 4'hA, 13'd2, 32'hFFFF_FFFF, 0, 0, 1'b0,  6, 2};
        vecs[6] = '{DMA_P2M, 4'h6, 13'd3, 32'h0000_0803, 2, 0, 1'b1, 12, 3};
        vecs[7] = '{3'b111,  4'h7, 13'd1, 32'h0000_2000, 0, 0, 1'b0,  0, 0};

        #1 chk_outputs_zero("reset_hold");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk_outputs_zero("post_reset");

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while the second of four words is in flight
        @(posedge clk_i); #1;
        clear_obs(); gnt_dly = 0; rdy_dly = 0;
        dma_en_i = 1'b1; dma_funct3_i = DMA_M2P; dma_sel_pim_i = 4'hC;
        dma_size_i = 13'd4; dma_mem_addr_i = 32'h3000_0000;
        @(posedge clk_i); #1;
        dma_en_i = 1'b0;
        t = 0;
        while (rd_q.size() < 2 && t < 100) begin @(negedge clk_i); t++; end
        chk("midrst_reached_word2", rd_q.size(), 2);
        #2 rst_ni = 1'b0;
        #1 chk_outputs_zero("midrst");
        busy_cnt = 0; done_cnt = 0;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_ni = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", busy_cnt, 0);
        run_vec(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
